// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg
// Shared definitions for the reset sequencer: the sequencer state encoding
// and its width. Imported by rst_sequencer.
package rst_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        WAIT_LOCK = 3'd0,
        LOCK_QUAL = 3'd1,
        INIT_WAIT = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        HOLD      = 3'd5
    } seq_state_e;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// One-bit two-flop synchroniser for bringing an asynchronous level into the
// clk domain. The output follows the input two clk edges later.
// Ports:
//   clk   - destination clock
//   clr_i - asynchronous active-high clear, forces both flops to 0
//   d_i   - asynchronous input level
//   q_o   - synchronised output
module sync_2ff (
    input  logic clk,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge clr_i) begin
        if (clr_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer
// Power-up / reset sequencer. Qualifies the PLL lock over LOCK_FILT cycles,
// waits INIT_DLY cycles, then releases NUM_CH active-low resets one by one,
// STAGE_DLY cycles apart (bit 0 first). Lock loss re-asserts every channel
// and restarts from WAIT_LOCK; a soft-reset request re-asserts every channel,
// holds for SOFT_DLY cycles after it drops, then re-releases without the
// INIT_DLY wait.
//
// Optional feature: define RST_SEQ_LOSS_CNT_EN to build an 8-bit saturating
// lock-loss event counter on loss_cnt; otherwise loss_cnt is tied to 0.
//
// Ports:
//   clk        - sequencing clock
//   rst        - asynchronous active-high reset
//   pll_locked - PLL lock, asynchronous to clk
//   soft_rst   - synchronous soft-reset request (level)
//   rst_n_out  - per-channel active-low resets, registered
//   all_done   - every channel released, registered
//   seq_state  - current state encoding (debug)
//   loss_cnt   - lock-loss event count
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 22,
    parameter int INIT_DLY  = 1000000,
    parameter int STAGE_DLY = 16,
    parameter int LOCK_FILT = 8,
    parameter int SOFT_DLY  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pll_locked,
    input  logic                soft_rst,
    output logic [NUM_CH-1:0]   rst_n_out,
    output logic                all_done,
    output logic [STATE_W-1:0]  seq_state,
    output logic [7:0]          loss_cnt
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Terminal counts. HOLD compares against SOFT_DLY (not SOFT_DLY-1)
    // because the first soft_rst-low cycle is seen one edge after it drops,
    // which places bit 0 at D+SOFT_DLY+1.
    localparam logic [CNT_W-1:0]  QUAL_LAST  = CNT_W'(LOCK_FILT - 1);
    localparam logic [CNT_W-1:0]  INIT_LAST  = CNT_W'(INIT_DLY - 1);
    localparam logic [CNT_W-1:0]  STAGE_LAST = CNT_W'(STAGE_DLY - 1);
    localparam logic [CNT_W-1:0]  SOFT_LAST  = CNT_W'(SOFT_DLY);
    localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] FIRST_REL  = NUM_CH'(1);
    localparam logic [NUM_CH-1:0] ALL_REL    = {NUM_CH{1'b1}};

    seq_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [CH_W-1:0]     ch_idx_q;
    logic [NUM_CH-1:0]   rst_n_q;
    logic [NUM_CH-1:0]   rst_n_d;
    logic                all_done_q;
    logic                lock_s;
    logic                lock_lost;
    logic                soft_take;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .clr_i (rst),
        .d_i   (pll_locked),
        .q_o   (lock_s)
    );

    assign cnt_d = cnt_q + CNT_W'(1);

    // Released bits form a thermometer code from bit 0 upward, so releasing
    // the next channel is a shift-in of a 1.
    assign rst_n_d = NUM_CH'({rst_n_q, 1'b1});

    // Every state except WAIT_LOCK falls back on lock loss. HOLD is included
    // so a lock drop during the soft hold cannot lead to a release without
    // a fresh lock qualification.
    assign lock_lost = !lock_s && (state_q != WAIT_LOCK);
    assign soft_take = soft_rst &&
                       ((state_q == INIT_WAIT) || (state_q == RELEASE) || (state_q == RUN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WAIT_LOCK;
            cnt_q      <= '0;
            ch_idx_q   <= '0;
            rst_n_q    <= '0;
            all_done_q <= 1'b0;
        end else if (lock_lost) begin
            // Lock loss outranks soft_rst.
            state_q    <= WAIT_LOCK;
            cnt_q      <= '0;
            ch_idx_q   <= '0;
            rst_n_q    <= '0;
            all_done_q <= 1'b0;
        end else if (soft_take) begin
            state_q    <= HOLD;
            cnt_q      <= '0;
            ch_idx_q   <= '0;
            rst_n_q    <= '0;
            all_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                WAIT_LOCK: begin
                    rst_n_q    <= '0;
                    all_done_q <= 1'b0;
                    if (lock_s) begin
                        state_q <= LOCK_QUAL;
                        cnt_q   <= '0;
                    end
                end
                LOCK_QUAL: begin
                    if (cnt_q == QUAL_LAST) begin
                        state_q <= INIT_WAIT;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                INIT_WAIT: begin
                    if (cnt_q == INIT_LAST) begin
                        state_q  <= RELEASE;
                        cnt_q    <= '0;
                        ch_idx_q <= '0;
                        rst_n_q  <= FIRST_REL;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RELEASE: begin
                    if (ch_idx_q == LAST_CH) begin
                        state_q    <= RUN;
                        all_done_q <= 1'b1;
                    end else if (cnt_q == STAGE_LAST) begin
                        ch_idx_q <= ch_idx_q + CH_W'(1);
                        rst_n_q  <= rst_n_d;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RUN: begin
                    rst_n_q    <= ALL_REL;
                    all_done_q <= 1'b1;
                end
                HOLD: begin
                    if (soft_rst) begin
                        cnt_q <= '0;
                    end else if (cnt_q == SOFT_LAST) begin
                        state_q  <= RELEASE;
                        cnt_q    <= '0;
                        ch_idx_q <= '0;
                        rst_n_q  <= FIRST_REL;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q    <= WAIT_LOCK;
                    cnt_q      <= '0;
                    ch_idx_q   <= '0;
                    rst_n_q    <= '0;
                    all_done_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef RST_SEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt_q;
    logic [7:0] loss_cnt_d;

    assign loss_cnt_d = loss_cnt_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loss_cnt_q <= 8'd0;
        end else if (lock_lost && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign loss_cnt = loss_cnt_q;
`else
    assign loss_cnt = 8'd0;
`endif

    assign rst_n_out = rst_n_q;
    assign all_done  = all_done_q;
    assign seq_state = state_q;

endmodule
